pulse2level: RTL
================

PULSE2LEVEL -- requirements
Module: pulse2level

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, number of cycles level_out stays high per trigger; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default $clog2(HOLD_CYCLES+1), width of the hold counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port pulse_in  input  1  single-cycle trigger, synchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous abort of an active hold.
REQ-007 SHALL have port level_out  output  1  registered stretched level.
REQ-008 SHALL have port done  output  1  registered one-cycle pulse when a hold expires naturally.
REQ-009 SHALL have port remain  output  CNT_W  registered remaining hold cycles, 0 when idle.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (level_out=0) and HOLD (level_out=1).
REQ-011 IDLE->HOLD SHALL occur when pulse_in=1 and clear=0; level_out rises the cycle after pulse_in (latency 1).
REQ-012 On entering HOLD, remain SHALL load HOLD_CYCLES-1 and decrement by 1 per cycle while in HOLD.
REQ-013 An isolated pulse_in SHALL produce level_out high for exactly HOLD_CYCLES consecutive cycles.
REQ-014 HOLD->IDLE SHALL occur on the cycle after remain=0; done SHALL be 1 on the first IDLE cycle only.
REQ-015 clear=1 SHALL force IDLE next cycle with remain=0 and done=0; clear has priority over pulse_in.
REQ-016 pulse_in held high for N cycles from IDLE SHALL be treated as repeated triggers per REQ-030/031, never as separate holds in IDLE.
REQ-017 HOLD_CYCLES=1 SHALL yield level_out high for exactly one cycle per accepted trigger, done the following cycle.
REQ-018 remain SHALL never underflow or wrap; it saturates at 0 in IDLE.
REQ-019 pulse_in in the same cycle as done SHALL start a new hold (IDLE acceptance rule applies).

Reset
REQ-020 rst=1 SHALL force state IDLE, level_out=0, done=0, remain=0 on the next clock edge, regardless of pulse_in or clear.
REQ-021 rst asserted mid-hold SHALL abort without asserting done.
REQ-022 rst SHALL have priority over clear and pulse_in.

Configuration
REQ-030 With macro PULSE2LEVEL_RETRIG_EN defined, pulse_in=1 in HOLD (clear=0) SHALL reload remain to HOLD_CYCLES-1, extending the level; a trigger on the remain=0 cycle keeps level_out high without a gap and without done.
REQ-031 Without PULSE2LEVEL_RETRIG_EN, pulse_in in HOLD SHALL be ignored, including on the remain=0 cycle; level falls and done fires on schedule.

Structure
REQ-040 A shared package SHALL hold the FSM state typedef (IDLE, HOLD) and the default HOLD_CYCLES constant.
REQ-041 The hold counter SHALL be a sub-module hold_counter (load, decrement, zero flag); the FSM stays in pulse2level.
REQ-042 All outputs SHALL be driven from flops; no combinational input-to-output path.

Verification
REQ-050 HOLD_CYCLES=4, one pulse_in at cycle 10 -> level_out high cycles 11-14, done=1 at cycle 15, remain 3,2,1,0.
REQ-051 HOLD_CYCLES=4, retrig build, pulses at cycles 10 and 13 -> level_out high cycles 11-17, single done at cycle 18; non-retrig build -> high 11-14, done at 15.
REQ-052 HOLD_CYCLES=4, pulse at 10, clear at 12 -> level_out high 11-12, low from 13, remain=0, done never asserted.
REQ-053 HOLD_CYCLES=4, pulse at 10, rst at 12 -> all outputs 0 from cycle 13; pulse and clear together at 20 -> stays IDLE.
REQ-054 HOLD_CYCLES=1, pulse_in high cycles 10-12, non-retrig build -> level_out high 11 and 13, done at 12 and 14; pulse at 12 accepted per REQ-019.

Source files
------------

// File: rtl/pulse2level_pkg.sv
// rtl/pulse2level_pkg.sv - shared FSM state type and default hold length for pulse2level
package pulse2level_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_HOLD_CYCLES = 16;

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - loadable down counter with zero flag, saturating at 0
module hold_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse2level.sv
// rtl/pulse2level.sv - stretches a trigger pulse into a HOLD_CYCLES-long level
// Define PULSE2LEVEL_RETRIG_EN to let triggers during a hold extend it.
module pulse2level
    import pulse2level_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clear,
    output logic             level_out,
    output logic             done,
    output logic [CNT_W-1:0] remain
);

`ifdef PULSE2LEVEL_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t state;
    state_t state_next;
    logic   done_next;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_clr;
    logic   cnt_zero;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_clr    = 1'b0;
        if (clear) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_in) begin
                        state_next = HOLD;
                        cnt_load   = 1'b1;
                    end
                end
                HOLD: begin
                    if (RETRIG && pulse_in) begin
                        cnt_load = 1'b1;
                    end else if (cnt_zero) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    // level_out is its own flop so the output never depends on decode logic
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            level_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            level_out <= (state_next == HOLD);
            done      <= done_next;
        end
    end

    hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (RELOAD),
        .count      (remain),
        .zero       (cnt_zero)
    );

endmodule
